// File: rtl/decode_out_rtl_pkg.sv
// Shared types for the decode-output stimulus player: queue entry layout,
// bubble instruction encoding and player FSM states.
package decode_out_rtl_pkg;

    localparam int DEF_IR_W   = 16;
    localparam int DEF_NPC_W  = 16;
    localparam int DEF_E_W    = 6;
    localparam int DEF_W_W    = 2;
    localparam int DEF_HOLD_W = 4;

    // All-zero IR decodes as a branch with no condition bits set, i.e. a NOP.
    localparam logic [15:0] BUBBLE_IR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Field order, MSB first, matches the ld_data packing seen by the loader.
    typedef struct packed {
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_NPC_W-1:0]  npc;
        logic [DEF_E_W-1:0]    e_ctrl;
        logic                  mem_ctrl;
        logic [DEF_W_W-1:0]    w_ctrl;
        logic [DEF_HOLD_W-1:0] hold;
    } decode_entry_t;

    localparam int DEF_ENTRY_W = $bits(decode_entry_t);

endpackage

// File: rtl/decode_out_fifo.sv
// Synchronous entry queue with flush. ready is a registered !full, so it is low
// through reset and rises on the first clock afterwards; a push is refused while
// full even if the same cycle pops.
module decode_out_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 45
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic [ENTRY_W-1:0]       wr_data,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        count_next;
    logic               push;
    logic               pop;

    assign push       = push_req & ready & ~flush;
    assign pop        = pop_req & (count != '0) & ~flush;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign empty      = (count == '0);
    assign level      = count;
    assign rd_data    = mem[rd_ptr];

    // Pointer, occupancy and ready bookkeeping; flush empties the queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/decode_out_stim_player.sv
// Plays queued decode-stage transactions onto the decode_out bus. Each entry is
// shown for 1+hold enabled cycles; on underrun the bus bubbles (or holds) and
// underrun pulses once when real data runs out.
module decode_out_stim_player
    import decode_out_rtl_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int IR_W        = 16,
    parameter int NPC_W       = 16,
    parameter int E_W         = 6,
    parameter int W_W         = 2,
    parameter int HOLD_W      = 4,
    parameter int BUBBLE_MODE = 1
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable_decode,
    input  logic                                     flush,
    input  logic                                     ld_valid,
    output logic                                     ld_ready,
    input  logic [IR_W+NPC_W+E_W+1+W_W+HOLD_W-1:0]   ld_data,
    output logic [E_W-1:0]                           E_control,
    output logic [NPC_W-1:0]                         npc_out,
    output logic                                     Mem_control,
    output logic [W_W-1:0]                           W_control,
    output logic [IR_W-1:0]                          IR,
    output logic                                     out_valid,
    output logic [$clog2(DEPTH):0]                   level,
    output logic                                     underrun
);
    localparam int ENTRY_W  = IR_W + NPC_W + E_W + 1 + W_W + HOLD_W;
    localparam int HOLD_LSB = 0;
    localparam int W_LSB    = HOLD_LSB + HOLD_W;
    localparam int MEM_LSB  = W_LSB + W_W;
    localparam int E_LSB    = MEM_LSB + 1;
    localparam int NPC_LSB  = E_LSB + E_W;
    localparam int IR_LSB   = NPC_LSB + NPC_W;

    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               pop_req;
    logic [HOLD_W-1:0]  hold_cnt;
    state_e             state;

    // Only ask for a new entry once the current one has used up its hold count.
    assign pop_req = enable_decode & ~flush & (hold_cnt == '0);

    decode_out_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push_req (ld_valid),
        .pop_req  (pop_req),
        .wr_data  (ld_data),
        .rd_data  (head),
        .ready    (ld_ready),
        .empty    (empty),
        .level    (level)
    );

    // Player FSM: issue, repeat or bubble the bus once per enabled cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            E_control   <= '0;
            npc_out     <= '0;
            Mem_control <= 1'b0;
            W_control   <= '0;
            IR          <= '0;
            out_valid   <= 1'b0;
            underrun    <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            if (BUBBLE_MODE != 0) begin
                IR          <= IR_W'(BUBBLE_IR);
                E_control   <= '0;
                Mem_control <= 1'b0;
                W_control   <= '0;
            end
        end else if (enable_decode) begin
            if (hold_cnt != '0) begin
                hold_cnt  <= hold_cnt - HOLD_W'(1);
                out_valid <= 1'b1;
                underrun  <= 1'b0;
                state     <= HOLD;
            end else if (!empty) begin
                IR          <= head[IR_LSB  +: IR_W];
                npc_out     <= head[NPC_LSB +: NPC_W];
                E_control   <= head[E_LSB   +: E_W];
                Mem_control <= head[MEM_LSB];
                W_control   <= head[W_LSB   +: W_W];
                hold_cnt    <= head[HOLD_LSB +: HOLD_W];
                out_valid   <= 1'b1;
                underrun    <= 1'b0;
                state       <= ISSUE;
            end else begin
                out_valid <= 1'b0;
                underrun  <= (state != IDLE);
                state     <= IDLE;
                if (BUBBLE_MODE != 0) begin
                    IR          <= IR_W'(BUBBLE_IR);
                    E_control   <= '0;
                    Mem_control <= 1'b0;
                    W_control   <= '0;
                end
            end
        end else begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_out_stim_player.sv
module tb_decode_out_stim_player;
    import decode_out_rtl_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        enable_decode = 1'b0;
    logic        flush = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [44:0] ld_data = '0;
    logic [5:0]  E_control;
    logic [15:0] npc_out;
    logic        Mem_control;
    logic [1:0]  W_control;
    logic [15:0] IR;
    logic        out_valid;
    logic [3:0]  level;
    logic        underrun;

    logic        b_enable = 1'b0;
    logic        b_flush = 1'b0;
    logic        b_ld_valid = 1'b0;
    logic        b_ld_ready;
    logic [44:0] b_ld_data = '0;
    logic [5:0]  b_E_control;
    logic [15:0] b_npc_out;
    logic        b_Mem_control;
    logic [1:0]  b_W_control;
    logic [15:0] b_IR;
    logic        b_out_valid;
    logic [3:0]  b_level;
    logic        b_underrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    decode_out_stim_player #(.BUBBLE_MODE(1)) dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .E_control(E_control), .npc_out(npc_out), .Mem_control(Mem_control),
        .W_control(W_control), .IR(IR), .out_valid(out_valid), .level(level),
        .underrun(underrun)
    );

    decode_out_stim_player #(.BUBBLE_MODE(0)) dut_hold (
        .clock(clock), .reset(reset), .enable_decode(b_enable), .flush(b_flush),
        .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_data(b_ld_data),
        .E_control(b_E_control), .npc_out(b_npc_out), .Mem_control(b_Mem_control),
        .W_control(b_W_control), .IR(b_IR), .out_valid(b_out_valid), .level(b_level),
        .underrun(b_underrun)
    );

    function automatic logic [44:0] mk(input logic [15:0] ir, input logic [15:0] npc,
                                       input logic [5:0] e, input logic mem,
                                       input logic [1:0] w, input logic [3:0] hold);
        decode_entry_t ent;
        ent.ir = ir; ent.npc = npc; ent.e_ctrl = e; ent.mem_ctrl = mem;
        ent.w_ctrl = w; ent.hold = hold;
        return ent;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        ld_valid = 1'b1;
        ld_data  = mk(16'hBEEF, 16'h1111, 6'h3F, 1'b1, 2'h3, 4'h0);
        repeat (3) tick();
        total_cnt++;
        if ({IR, npc_out, E_control, Mem_control, W_control, out_valid, underrun} !== '0)
            $display("FAIL reset_outputs got IR=%h npc=%h E=%h valid=%b want all 0", IR, npc_out, E_control, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        total_cnt++;
        if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL release_ld_ready_early got %b want 0", ld_ready); else pass_cnt++;
        tick();
        total_cnt++;
        if (ld_ready !== 1'b1 || b_ld_ready !== 1'b1)
            $display("FAIL release_ld_ready got %b/%b want 1/1", ld_ready, b_ld_ready);
        else pass_cnt++;
        total_cnt++;
        if (level !== 4'd0) $display("FAIL release_level got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_basic_hold();
        logic [15:0] exp_ir [4];
        exp_ir[0] = 16'h1261; exp_ir[1] = 16'h5020; exp_ir[2] = 16'h5020; exp_ir[3] = 16'h5020;
        enable_decode = 1'b1;
        ld_valid = 1'b1;
        ld_data  = mk(16'h1261, 16'h3001, 6'h15, 1'b1, 2'h2, 4'd0);
        tick();
        ld_data  = mk(16'h5020, 16'h3002, 6'h0A, 1'b0, 2'h1, 4'd2);
        tick();
        ld_valid = 1'b0;
        total_cnt++;
        if (level !== 4'd1) $display("FAIL b2b_level got %0d want 1", level); else pass_cnt++;
        total_cnt++;
        if (npc_out !== 16'h3001 || E_control !== 6'h15 || Mem_control !== 1'b1 || W_control !== 2'h2)
            $display("FAIL issue_fields got npc=%h E=%h M=%b W=%h want 3001/15/1/2", npc_out, E_control, Mem_control, W_control);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if (IR !== exp_ir[i] || out_valid !== 1'b1 || underrun !== 1'b0)
                $display("FAIL seq_ir[%0d] got IR=%h valid=%b und=%b want %h/1/0", i, IR, out_valid, underrun, exp_ir[i]);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (IR !== 16'h0000 || out_valid !== 1'b0 || underrun !== 1'b1 || E_control !== 6'h0 || npc_out !== 16'h3002)
            $display("FAIL bubble got IR=%h valid=%b und=%b E=%h npc=%h want 0000/0/1/00/3002", IR, out_valid, underrun, E_control, npc_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (underrun !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL underrun_once got und=%b valid=%b want 0/0", underrun, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        enable_decode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_data  = mk(16'hA000 + 16'(i), 16'h4000 + 16'(i), 6'(i), 1'b0, 2'h0, 4'd0);
            tick();
            total_cnt++;
            if (level !== 4'(i + 1)) $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1); else pass_cnt++;
        end
        total_cnt++;
        if (ld_ready !== 1'b0) $display("FAIL full_ld_ready got %b want 0", ld_ready); else pass_cnt++;
        ld_data = mk(16'hFFFF, 16'hFFFF, 6'h3F, 1'b1, 2'h3, 4'd0);
        tick();
        ld_valid = 1'b0;
        total_cnt++;
        if (level !== 4'd8) $display("FAIL ninth_push_level got %0d want 8", level); else pass_cnt++;
        enable_decode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if (IR !== 16'hA000 + 16'(i) || level !== 4'(7 - i) || out_valid !== 1'b1)
                $display("FAIL drain[%0d] got IR=%h level=%0d valid=%b want %h/%0d/1", i, IR, level, out_valid, 16'hA000 + 16'(i), 7 - i);
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (ld_ready !== 1'b1) $display("FAIL ready_after_pop got %b want 1", ld_ready); else pass_cnt++;
            end
        end
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || underrun !== 1'b1 || IR !== 16'h0000)
            $display("FAIL drain_bubble got valid=%b und=%b IR=%h want 0/1/0000", out_valid, underrun, IR);
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        int seen;
        enable_decode = 1'b0;
        ld_valid = 1'b1;
        ld_data  = mk(16'h2222, 16'h5000, 6'h01, 1'b0, 2'h1, 4'd3);
        tick();
        ld_valid = 1'b0;
        enable_decode = 1'b1;
        seen = 0;
        repeat (2) begin
            tick();
            if (IR === 16'h2222 && out_valid === 1'b1) seen++;
        end
        enable_decode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (IR !== 16'h2222 || out_valid !== 1'b1 || underrun !== 1'b0)
                $display("FAIL frozen[%0d] got IR=%h valid=%b und=%b want 2222/1/0", i, IR, out_valid, underrun);
            else pass_cnt++;
        end
        enable_decode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (IR === 16'h2222 && out_valid === 1'b1) seen++;
            else break;
        end
        total_cnt++;
        if (seen !== 4) $display("FAIL hold_cycles got %0d want 4", seen); else pass_cnt++;
        total_cnt++;
        if (underrun !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL hold_end got und=%b valid=%b want 1/0", underrun, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        enable_decode = 1'b0;
        ld_valid = 1'b1;
        ld_data  = mk(16'h4444, 16'h6000, 6'h02, 1'b1, 2'h2, 4'd5);
        tick();
        ld_valid = 1'b0;
        enable_decode = 1'b1;
        tick();
        enable_decode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = mk(16'h7000 + 16'(i), 16'h7000, 6'h00, 1'b0, 2'h0, 4'd0);
            tick();
        end
        total_cnt++;
        if (level !== 4'd5 || IR !== 16'h4444 || out_valid !== 1'b1)
            $display("FAIL preflush got level=%0d IR=%h valid=%b want 5/4444/1", level, IR, out_valid);
        else pass_cnt++;
        flush = 1'b1;
        enable_decode = 1'b1;
        ld_data = mk(16'hDEAD, 16'hDEAD, 6'h3F, 1'b1, 2'h3, 4'd0);
        tick();
        flush = 1'b0;
        ld_valid = 1'b0;
        total_cnt++;
        if (level !== 4'd0 || out_valid !== 1'b0 || underrun !== 1'b0 || IR !== 16'h0000 || E_control !== 6'h0)
            $display("FAIL flush got level=%0d valid=%b und=%b IR=%h E=%h want 0/0/0/0000/00", level, out_valid, underrun, IR, E_control);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0 || IR === 16'hDEAD || underrun !== 1'b0)
                $display("FAIL post_flush[%0d] got valid=%b IR=%h und=%b want 0/not DEAD/0", i, out_valid, IR, underrun);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_mode();
        b_enable   = 1'b1;
        b_ld_valid = 1'b1;
        b_ld_data  = mk(16'h1234, 16'h3004, 6'h11, 1'b1, 2'h1, 4'd0);
        tick();
        b_ld_valid = 1'b0;
        tick();
        total_cnt++;
        if (b_IR !== 16'h1234 || b_npc_out !== 16'h3004 || b_out_valid !== 1'b1)
            $display("FAIL hm_issue got IR=%h npc=%h valid=%b want 1234/3004/1", b_IR, b_npc_out, b_out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_IR !== 16'h1234 || b_npc_out !== 16'h3004 || b_E_control !== 6'h11 || b_out_valid !== 1'b0 || b_underrun !== 1'b1)
            $display("FAIL hm_underrun got IR=%h npc=%h E=%h valid=%b und=%b want 1234/3004/11/0/1", b_IR, b_npc_out, b_E_control, b_out_valid, b_underrun);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b_IR !== 16'h1234 || b_npc_out !== 16'h3004 || b_out_valid !== 1'b0 || b_underrun !== 1'b0)
            $display("FAIL hm_idle got IR=%h npc=%h valid=%b und=%b want 1234/3004/0/0", b_IR, b_npc_out, b_out_valid, b_underrun);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_hold();
        test_fill();
        test_freeze();
        test_flush();
        test_hold_mode();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
